// File: rtl/uart_tx_pkg.sv
// Shared definitions for the UART transmitter: FSM state encoding,
// bit timing constant and counter sizing helper.
package uart_tx_pkg;

    // 16x oversampling: one data bit lasts this many baud ticks
    localparam int TICKS_PER_BIT = 16;

    localparam logic HIGH = 1'b1;
    localparam logic LOW  = 1'b0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_e;

    // Tick counter must reach both 15 (bit cells) and STOP_TICKS-1 (stop cell)
    function automatic int tick_cnt_width(input int stop_ticks);
        int w;
        w = $clog2(stop_ticks);
        return (w > 4) ? w : 4;
    endfunction

endpackage

// File: rtl/uart_tx_if.sv
// FIFO-side and line-side signals of the UART transmitter.
// master: the transmitter; slave: the FIFO / baud source / line consumer.
interface uart_tx_if #(
    parameter int WORD_WIDTH = 8
);
    logic                  tick;
    logic                  fifo_empty;
    logic [WORD_WIDTH-1:0] fifo_rdata;
    logic                  fifo_rd;
    logic                  tx;
    logic                  tx_busy;
    logic                  tx_done;

    modport master (
        input  tick, fifo_empty, fifo_rdata,
        output fifo_rd, tx, tx_busy, tx_done
    );

    modport slave (
        output tick, fifo_empty, fifo_rdata,
        input  fifo_rd, tx, tx_busy, tx_done
    );
endinterface

// File: rtl/uart_tx.sv
// UART transmitter: pops a word from a first-word-fall-through FIFO when
// idle and sends start bit, WORD_WIDTH data bits LSB first, and a stop
// period of STOP_TICKS baud ticks. All timing is driven by the 16x tick.
module uart_tx
    import uart_tx_pkg::*;
#(
    parameter int WORD_WIDTH = 8,
    parameter int STOP_TICKS = 16
) (
    input  logic      clk,
    input  logic      reset,
    uart_tx_if.master bus
);

    localparam int TW = tick_cnt_width(STOP_TICKS);
    localparam int BW = (WORD_WIDTH > 1) ? $clog2(WORD_WIDTH) : 1;

    localparam logic [TW-1:0] TICK_LAST = TW'(TICKS_PER_BIT - 1);
    localparam logic [TW-1:0] STOP_LAST = TW'(STOP_TICKS - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(WORD_WIDTH - 1);

    state_e                state_q, state_d;
    logic [TW-1:0]         tick_cnt_q, tick_cnt_d;
    logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
    logic [WORD_WIDTH-1:0] shift_q, shift_d;
    logic                  tx_q, tx_d;
    logic                  busy_q, busy_d;
    logic                  pop;
    logic                  frame_end;

    // Next-state, datapath and Mealy strobes; tx/busy are precomputed from
    // the next state so the registered copies change on the transition edge
    always_comb begin
        state_d    = state_q;
        tick_cnt_d = tick_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        pop        = 1'b0;
        frame_end  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                pop = ~bus.fifo_empty & ~reset;
                if (pop) begin
                    shift_d    = bus.fifo_rdata;
                    tick_cnt_d = '0;
                    bit_cnt_d  = '0;
                    state_d    = ST_START;
                end
            end
            ST_START: begin
                if (bus.tick) begin
                    if (tick_cnt_q == TICK_LAST) begin
                        tick_cnt_d = '0;
                        bit_cnt_d  = '0;
                        state_d    = ST_DATA;
                    end else begin
                        tick_cnt_d = tick_cnt_q + TW'(1);
                    end
                end
            end
            ST_DATA: begin
                if (bus.tick) begin
                    if (tick_cnt_q == TICK_LAST) begin
                        tick_cnt_d = '0;
                        shift_d    = shift_q >> 1;
                        if (bit_cnt_q == BIT_LAST) begin
                            bit_cnt_d = '0;
                            state_d   = ST_STOP;
                        end else begin
                            bit_cnt_d = bit_cnt_q + BW'(1);
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + TW'(1);
                    end
                end
            end
            ST_STOP: begin
                if (bus.tick) begin
                    if (tick_cnt_q == STOP_LAST) begin
                        tick_cnt_d = '0;
                        bit_cnt_d  = '0;
                        frame_end  = ~reset;
                        state_d    = ST_IDLE;
                    end else begin
                        tick_cnt_d = tick_cnt_q + TW'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        case (state_d)
            ST_START: tx_d = LOW;
            ST_DATA:  tx_d = shift_d[0];
            default:  tx_d = HIGH;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // State and datapath registers; reset abandons any frame in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            tick_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            tx_q       <= HIGH;
            busy_q     <= LOW;
        end else begin
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
        end
    end

    assign bus.fifo_rd = pop;
    assign bus.tx      = tx_q;
    assign bus.tx_busy = busy_q;
    assign bus.tx_done = frame_end;

endmodule
